// File: rtl/nn_layer_pkg.sv
// -----------------------------------------------------------------------------
// nn_layer_pkg
// Shared definitions for the layer-register fetch blocks:
//   - default entry width and register depth,
//   - a constant clog2 helper and the derived index / length widths,
//   - the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package nn_layer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 56;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fetch_state_e;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Entry index width; never narrower than one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Burst length width; must be able to represent the value DEPTH itself.
    function automatic int len_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_entry_mux.sv
// -----------------------------------------------------------------------------
// reg_entry_mux
// Purely combinational entry selector for a packed layer-output vector.
// Ports:
//   vec  [0:DATA_W*DEPTH-1]  packed entries, entry i occupies bits
//                            [i*DATA_W : i*DATA_W+DATA_W-1], lowest index = MSB
//   idx  [IDX_W-1:0]         entry index
//   data [DATA_W-1:0]        selected entry, zero when idx >= DEPTH
// -----------------------------------------------------------------------------
module reg_entry_mux
    import nn_layer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic [0:DATA_W*DEPTH-1] vec,
    input  logic [IDX_W-1:0]        idx,
    output logic [DATA_W-1:0]       data
);

    localparam int              SEL_W   = clog2(DATA_W * DEPTH);
    localparam logic [IDX_W:0]  DEPTH_C = (IDX_W + 1)'(DEPTH);

    logic [SEL_W-1:0] base_s;

    // Slice selection: the ascending vector makes the lowest bit of the slice the MSB.
    always_comb begin
        base_s = SEL_W'(idx) * SEL_W'(DATA_W);
        if ({1'b0, idx} < DEPTH_C) begin
            data = vec[base_s +: DATA_W];
        end else begin
            data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/layer_reg_burst_fetch.sv
// -----------------------------------------------------------------------------
// layer_reg_burst_fetch
// Streams a burst of consecutive DATA_W entries out of a packed layer-output
// vector under a valid/ready handshake. Requests running past the end of the
// register are rejected with a one-cycle err pulse.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   layer_reg         packed entries (entry i at bits [i*DATA_W +: DATA_W])
//   fetch             request strobe, only looked at while idle
//   start_no          first entry of the burst
//   burst_len         number of entries to stream
//   out_ready         consumer accepts the current beat
//   fetched           beat valid
//   value             beat data
//   last              final beat of the burst (qualified by fetched)
//   busy              burst in progress
//   err               one-cycle pulse, request rejected
// Build option:
//   LAYER_REG_SNAPSHOT_EN  copy layer_reg on acceptance so every beat of the
//                          burst reads a coherent image.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module layer_reg_burst_fetch
    import nn_layer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = idx_w(DEPTH),
    parameter int LEN_W  = len_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:DATA_W*DEPTH-1] layer_reg,
    input  logic                    fetch,
    input  logic [IDX_W-1:0]        start_no,
    input  logic [LEN_W-1:0]        burst_len,
    input  logic                    out_ready,
    output logic                    fetched,
    output logic [DATA_W-1:0]       value,
    output logic                    last,
    output logic                    busy,
    output logic                    err
);

    localparam logic [LEN_W:0] DEPTH_C = (LEN_W + 1)'(DEPTH);

    fetch_state_e         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;
    logic                 fetched_q, fetched_d;
    logic [DATA_W-1:0]    value_q, value_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [LEN_W:0]          req_end_s;
    logic                    req_legal_s;
    logic                    xfer_s;
    logic [IDX_W-1:0]        mux_idx_s;
    logic [DATA_W-1:0]       mux_data_s;
    logic [0:DATA_W*DEPTH-1] src_vec_s;

    // Request legality, evaluated one bit wider than LEN_W so start+len cannot wrap.
    always_comb begin
        req_end_s   = (LEN_W + 1)'(start_no) + (LEN_W + 1)'(burst_len);
        req_legal_s = ((LEN_W + 1)'(start_no) < DEPTH_C) &&
                      (burst_len != {LEN_W{1'b0}}) &&
                      (req_end_s <= DEPTH_C);
    end

`ifdef LAYER_REG_SNAPSHOT_EN
    logic [0:DATA_W*DEPTH-1] snap_q, snap_d;

    // Capture the whole register image when a burst is accepted.
    always_comb begin
        if ((state_q == IDLE) && fetch && req_legal_s) begin
            snap_d = layer_reg;
        end else begin
            snap_d = snap_q;
        end
    end

    // Snapshot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= {(DATA_W * DEPTH){1'b0}};
        end else begin
            snap_q <= snap_d;
        end
    end

    // First beat comes from the live register (identical to the image being
    // captured); later beats read the snapshot.
    always_comb begin
        if (state_q == IDLE) begin
            src_vec_s = layer_reg;
        end else begin
            src_vec_s = snap_q;
        end
    end
`else
    // Without a snapshot every beat samples the live register.
    always_comb begin
        src_vec_s = layer_reg;
    end
`endif

    // Index of the entry to load next: the burst start when idle, ptr+1 while streaming.
    always_comb begin
        case (state_q)
            IDLE:    mux_idx_s = start_no;
            STREAM:  mux_idx_s = ptr_q + IDX_W'(1);
            default: mux_idx_s = start_no;
        endcase
    end

    reg_entry_mux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_entry_mux (
        .vec  (src_vec_s),
        .idx  (mux_idx_s),
        .data (mux_data_s)
    );

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        fetched_d   = fetched_q;
        value_d     = value_q;
        last_d      = last_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        xfer_s      = fetched_q & out_ready;

        case (state_q)
            IDLE: begin
                if (fetch) begin
                    if (req_legal_s) begin
                        state_d     = STREAM;
                        busy_d      = 1'b1;
                        fetched_d   = 1'b1;
                        value_d     = mux_data_s;
                        last_d      = (burst_len == LEN_W'(1));
                        ptr_d       = start_no;
                        remaining_d = burst_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            STREAM: begin
                // Any fetch seen here, including during the final transfer, is dropped.
                if (xfer_s) begin
                    if (last_q) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        fetched_d = 1'b0;
                        last_d    = 1'b0;
                    end else begin
                        ptr_d       = ptr_q + IDX_W'(1);
                        remaining_d = remaining_q - LEN_W'(1);
                        value_d     = mux_data_s;
                        // remaining counts the beat currently presented, so 2 means the
                        // beat being loaded now is the final one.
                        last_d      = (remaining_q == LEN_W'(2));
                    end
                end else begin
                    fetched_d = fetched_q;
                end
            end
            default: begin
                state_d     = IDLE;
                ptr_d       = {IDX_W{1'b0}};
                remaining_d = {LEN_W{1'b0}};
                fetched_d   = 1'b0;
                value_d     = {DATA_W{1'b0}};
                last_d      = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= {IDX_W{1'b0}};
            remaining_q <= {LEN_W{1'b0}};
            fetched_q   <= 1'b0;
            value_q     <= {DATA_W{1'b0}};
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            fetched_q   <= fetched_d;
            value_q     <= value_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign fetched = fetched_q;
    assign value   = value_q;
    assign last    = last_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_layer_reg_burst_fetch.sv
// -----------------------------------------------------------------------------
// tb_layer_reg_burst_fetch
// Table of burst requests with per-cycle out_ready patterns; expected beats
// are pushed to a scoreboard queue when a request is driven and popped as the
// DUT presents them. Reset-during-burst is a hand-written sequence.
// Honours LAYER_REG_SNAPSHOT_EN for the mid-burst register change case.
// -----------------------------------------------------------------------------
module tb_layer_reg_burst_fetch;

    localparam int DW = 16;
    localparam int DP = 56;

    logic              clk;
    logic              rst_n;
    logic [0:DW*DP-1]  layer_reg;
    logic              fetch;
    logic [5:0]        start_no;
    logic [5:0]        burst_len;
    logic              out_ready;
    logic              fetched;
    logic [DW-1:0]     value;
    logic              last;
    logic              busy;
    logic              err;

    logic [15:0] mem [DP];
    logic [15:0] sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          start;
        int          len;
        logic [15:0] pat;       // out_ready for cycle k (k < 16), then 1
        int          extra_at;  // cycle to raise a stray fetch, -1 for none
        bit          poke;      // overwrite entry 12 after acceptance
    } vec_t;

    vec_t tbl [10];

    layer_reg_burst_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .layer_reg (layer_reg),
        .fetch     (fetch),
        .start_no  (start_no),
        .burst_len (burst_len),
        .out_ready (out_ready),
        .fetched   (fetched),
        .value     (value),
        .last      (last),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < DP; i++) begin
            layer_reg[i*DW +: DW] = mem[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        bit          legal;
        int          k;
        int          xfers;
        logic [15:0] e;
        logic [15:0] last_exp;
        legal = (v.start < DP) && (v.len != 0) && (v.start + v.len <= DP);
        sb.delete();
        last_exp = 16'h0000;
        if (legal) begin
            for (int j = 0; j < v.len; j++) begin
                e = mem[v.start + j];
`ifndef LAYER_REG_SNAPSHOT_EN
                if (v.poke && (j > 0) && (v.start + j == 12)) e = 16'hBEEF;
`endif
                sb.push_back(e);
                last_exp = e;
            end
        end
        fetch     = 1'b1;
        start_no  = 6'(v.start);
        burst_len = 6'(v.len);
        out_ready = 1'b1;
        @(posedge clk); #1;
        fetch = 1'b0;
        if (v.poke) mem[12] = 16'hBEEF;
        if (!legal) begin
            check("rej_err", {31'd0, err}, 32'd1);
            check("rej_fetched", {31'd0, fetched}, 32'd0);
            check("rej_busy", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check("rej_err_pulse", {31'd0, err}, 32'd0);
            check("rej_fetched2", {31'd0, fetched}, 32'd0);
            return;
        end
        check("acc_busy", {31'd0, busy}, 32'd1);
        k = 0;
        xfers = 0;
        while (sb.size() > 0 && k < 400) begin
            out_ready = (k < 16) ? v.pat[k] : 1'b1;
            if (v.extra_at == k) begin
                fetch = 1'b1; start_no = 6'd0; burst_len = 6'd1;
            end else begin
                fetch = 1'b0;
            end
            check("beat_valid", {31'd0, fetched}, 32'd1);
            check("beat_err", {31'd0, err}, 32'd0);
            check("beat_value", {16'd0, value}, {16'd0, sb[0]});
            check("beat_last", {31'd0, last}, {31'd0, (sb.size() == 1)});
            if (out_ready) begin
                void'(sb.pop_front());
                xfers++;
            end
            @(posedge clk); #1;
            k++;
        end
        fetch = 1'b0;
        check("burst_timeout", {31'd0, (k < 400)}, 32'd1);
        check("xfer_count", xfers, v.len);
        check("end_fetched", {31'd0, fetched}, 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_last", {31'd0, last}, 32'd0);
        check("end_err", {31'd0, err}, 32'd0);
        check("end_value_hold", {16'd0, value}, {16'd0, last_exp});
        if (v.poke) mem[12] = 16'h100C;
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < DP; i++) mem[i] = 16'h1000 + 16'(i);
        tbl[0] = '{0,  1,  16'hFFFF, -1, 1'b0};
        tbl[1] = '{53, 3,  16'hFFF9, -1, 1'b0};
        tbl[2] = '{55, 2,  16'hFFFF, -1, 1'b0};
        tbl[3] = '{56, 1,  16'hFFFF, -1, 1'b0};
        tbl[4] = '{5,  0,  16'hFFFF, -1, 1'b0};
        tbl[5] = '{10, 20, 16'hFFFF, 3,  1'b0};
        tbl[6] = '{0,  56, 16'hFFFF, -1, 1'b0};
        tbl[7] = '{1,  56, 16'hFFFF, -1, 1'b0};
        tbl[8] = '{10, 4,  16'hFFFF, -1, 1'b1};
        tbl[9] = '{30, 7,  16'h5555, -1, 1'b0};

        rst_n = 1'b0; fetch = 1'b0; start_no = 6'd0; burst_len = 6'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetched", {31'd0, fetched}, 32'd0);
        check("rst_value", {16'd0, value}, 32'd0);
        check("rst_last", {31'd0, last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 10; t++) begin
            run_burst(tbl[t]);
            @(posedge clk); #1;
        end

        // Reset asserted while beat 5 of a 10-beat burst is presented.
        sb.delete();
        for (int j = 0; j < 10; j++) sb.push_back(mem[j]);
        fetch = 1'b1; start_no = 6'd0; burst_len = 6'd10; out_ready = 1'b1;
        @(posedge clk); #1;
        fetch = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("mr_beat", {16'd0, value}, {16'd0, sb[0]});
            void'(sb.pop_front());
            @(posedge clk); #1;
        end
        check("mr_beat5", {16'd0, value}, {16'd0, sb[0]});
        rst_n = 1'b0;
        #1;
        check("mr_fetched", {31'd0, fetched}, 32'd0);
        check("mr_value", {16'd0, value}, 32'd0);
        check("mr_last", {31'd0, last}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        check("mr_still_idle", {31'd0, fetched}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mr_no_beats", {31'd0, fetched}, 32'd0);
        rv = '{40, 3, 16'hFFFF, -1, 1'b0};
        run_burst(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
